mac_feeder: RTL and testbench

- Sequencing stage directly upstream of the MAC unit.
- On a start pulse it reads FILT_SIZE window/filter byte pairs from two synchronous-read buffers and streams them into the MAC with the correct clear and accumulate-enable timing.
- It then captures the MAC's 8-bit result and presents it downstream on a valid/ready handshake.
- One instance per MAC lane.

---
 rtl/mac_feeder.sv | 132 +++++++++++++
 tb/tb_mac_feeder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_feeder.sv
// mac_feeder: sequencing stage in front of one MAC lane.
// On start it reads FILT_SIZE window/filter byte pairs from two synchronous-read buffers.
// It streams each pair into the MAC with the matching clear and accumulate-enable timing.
// It then captures the MAC result and offers it downstream on a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start                    request one output (sampled only when idle)
//   win_base, filt_base      first buffer addresses, latched with start
//   rd_en, win_addr,         buffer read strobe and addresses (data returns one cycle later)
//   filt_addr
//   win_data, filt_data      buffer read data
//   mac_window, mac_filter   operands to the MAC (pass-through of buffer data)
//   mac_reg_en               MAC accumulate enable
//   mac_clean_reg            MAC accumulator clear
//   mac_result               MAC result
//   out_data, out_valid,     captured result and its valid/ready handshake
//   out_ready
//   busy                     high whenever not idle
module mac_feeder #(
  parameter int unsigned FILT_SIZE = 4,
  parameter int unsigned ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] win_base,
  input  logic [ADDR_W-1:0] filt_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] win_addr,
  output logic [ADDR_W-1:0] filt_addr,
  input  logic [7:0]        win_data,
  input  logic [7:0]        filt_data,
  output logic [7:0]        mac_window,
  output logic [7:0]        mac_filter,
  output logic              mac_reg_en,
  output logic              mac_clean_reg,
  input  logic [7:0]        mac_result,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int unsigned KW = (FILT_SIZE > 1) ? $clog2(FILT_SIZE) : 1;
  localparam logic [KW-1:0] KLast = KW'(FILT_SIZE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRead,
    StDrain,
    StCapture,
    StOut
  } state_e;

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [ADDR_W-1:0] win_base_q, win_base_d;
  logic [ADDR_W-1:0] filt_base_q, filt_base_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              mac_reg_en_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      k_q          <= '0;
      win_base_q   <= '0;
      filt_base_q  <= '0;
      out_data_q   <= '0;
      mac_reg_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      win_base_q   <= win_base_d;
      filt_base_q  <= filt_base_d;
      out_data_q   <= out_data_d;
      // Buffer data lands one cycle after the read strobe, so the enable lags by one.
      mac_reg_en_q <= rd_en;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    win_base_d  = win_base_q;
    filt_base_d = filt_base_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          win_base_d  = win_base;
          filt_base_d = filt_base;
          k_d         = '0;
          state_d     = StClear;
        end
      end
      StClear: state_d = StRead;
      StRead: begin
        if (k_q == KLast) begin
          k_d     = '0;
          state_d = StDrain;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      // Last pair is being accumulated this cycle.
      StDrain: state_d = StCapture;
      StCapture: begin
        out_data_d = mac_result;
        state_d    = StOut;
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_en         = (state_q == StRead);
  // Addresses wrap naturally at ADDR_W bits.
  assign win_addr      = rd_en ? (win_base_q + ADDR_W'(k_q)) : '0;
  assign filt_addr     = rd_en ? (filt_base_q + ADDR_W'(k_q)) : '0;
  assign mac_window    = win_data;
  assign mac_filter    = filt_data;
  assign mac_reg_en    = mac_reg_en_q;
  assign mac_clean_reg = (state_q == StClear);
  assign out_data      = out_data_q;
  assign out_valid     = (state_q == StOut);
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder: three lanes (FILT_SIZE 4, 16, 1) share one pair of
// behavioural buffers; each lane has its own behavioural MAC (upper 8 product bits,
// 12-bit accumulate, result = acc[11:4]).
module tb_mac_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start     [3];
  logic [5:0] win_base  [3];
  logic [5:0] filt_base [3];
  logic       rd_en     [3];
  logic [5:0] win_addr  [3];
  logic [5:0] filt_addr [3];
  logic [7:0] mac_window[3];
  logic [7:0] mac_filter[3];
  logic       mac_reg_en[3];
  logic       mac_clean [3];
  logic [7:0] mac_result[3];
  logic [7:0] out_data  [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic       busy      [3];

  logic [7:0] wmem [64];
  logic [7:0] fmem [64];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int unsigned Fs = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
    logic [7:0]  wd;
    logic [7:0]  fd;
    logic [11:0] acc;

    mac_feeder #(.FILT_SIZE(Fs), .ADDR_W(6)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start[g]),
      .win_base     (win_base[g]),
      .filt_base    (filt_base[g]),
      .rd_en        (rd_en[g]),
      .win_addr     (win_addr[g]),
      .filt_addr    (filt_addr[g]),
      .win_data     (wd),
      .filt_data    (fd),
      .mac_window   (mac_window[g]),
      .mac_filter   (mac_filter[g]),
      .mac_reg_en   (mac_reg_en[g]),
      .mac_clean_reg(mac_clean[g]),
      .mac_result   (mac_result[g]),
      .out_data     (out_data[g]),
      .out_valid    (out_valid[g]),
      .out_ready    (out_ready[g]),
      .busy         (busy[g])
    );

    always @(posedge clk) begin
      if (rd_en[g]) begin
        wd <= wmem[win_addr[g]];
        fd <= fmem[filt_addr[g]];
      end
      if (mac_clean[g]) acc <= '0;
      else if (mac_reg_en[g])
        acc <= acc + 12'((16'(mac_window[g]) * 16'(mac_filter[g])) >> 8);
    end

    assign mac_result[g] = acc[11:4];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 64; i++) begin
      wmem[i] = v;
      fmem[i] = v;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] addr_log [16];

  // Issues one start and watches the lane until out_valid (bounded). Edge n is the n-th
  // rising edge after the one that sampled start.
  task automatic run_op(input int ln, input logic [5:0] wb, input logic [5:0] fb,
                        output int v_edge, output int rd_cnt, output int en_cnt,
                        output int first_rd, output int first_en);
    win_base[ln]  = wb;
    filt_base[ln] = fb;
    start[ln]     = 1'b1;
    tick();
    start[ln] = 1'b0;
    v_edge = -1; rd_cnt = 0; en_cnt = 0; first_rd = -1; first_en = -1;
    for (int n = 1; n <= 40 && v_edge < 0; n++) begin
      tick();
      if (rd_en[ln]) begin
        if (first_rd < 0) first_rd = n;
        if (rd_cnt < 16) addr_log[rd_cnt] = win_addr[ln];
        rd_cnt++;
      end
      if (mac_reg_en[ln]) begin
        if (first_en < 0) first_en = n;
        en_cnt++;
      end
      if (out_valid[ln]) v_edge = n;
    end
  endtask

  task automatic accept(input int ln, input string tag);
    out_ready[ln] = 1'b1;
    tick();
    out_ready[ln] = 1'b0;
    check({tag, "_accept_valid"}, 32'(out_valid[ln]), 32'd0);
    check({tag, "_accept_idle"}, 32'(busy[ln]), 32'd0);
  endtask

  int v_edge, rd_cnt, en_cnt, first_rd, first_en, extra_rd;

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; out_ready[i] = 1'b0; win_base[i] = '0; filt_base[i] = '0;
    end
    fill(8'h00);
    tick();
    tick();
    check("rst_rd_en", 32'(rd_en[0]), 32'd0);
    check("rst_reg_en", 32'(mac_reg_en[0]), 32'd0);
    check("rst_clean", 32'(mac_clean[0]), 32'd0);
    check("rst_valid", 32'(out_valid[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_data", 32'(out_data[0]), 32'd0);
    check("rst_waddr", 32'(win_addr[0]), 32'd0);
    check("rst_faddr", 32'(filt_addr[0]), 32'd0);
    rst = 1'b1;
    tick();

    // 0x80 * 0x80 -> 0x40 per product, 4 products -> acc 0x100 -> 0x10.
    fill(8'h80);
    run_op(0, 6'd10, 6'd20, v_edge, rd_cnt, en_cnt, first_rd, first_en);
    check("t1_latency", 32'(v_edge), 32'd7);
    check("t1_rd_cnt", 32'(rd_cnt), 32'd4);
    check("t1_en_cnt", 32'(en_cnt), 32'd4);
    check("t1_first_rd", 32'(first_rd), 32'd1);
    check("t1_en_lag", 32'(first_en), 32'd2);
    check("t1_data", 32'(out_data[0]), 32'h10);

    // Hold off downstream; starts during busy must not trigger reads.
    extra_rd = 0;
    for (int i = 0; i < 10; i++) begin
      start[0] = i[0];
      tick();
      if (rd_en[0]) extra_rd++;
      check("hold_valid", 32'(out_valid[0]), 32'd1);
      check("hold_data", 32'(out_data[0]), 32'h10);
    end
    check("hold_no_rd", 32'(extra_rd), 32'd0);
    // start coincident with the accepting edge is ignored.
    start[0] = 1'b1;
    accept(0, "t1");
    start[0] = 1'b0;
    tick();
    check("t1_start_ignored", 32'(busy[0]), 32'd0);

    // 0xFF*0xFF -> 0xFE, x4 -> 0x3F8 -> 0x3F; window addresses wrap.
    fill(8'hFF);
    run_op(0, 6'd62, 6'd5, v_edge, rd_cnt, en_cnt, first_rd, first_en);
    check("t2_data", 32'(out_data[0]), 32'h3F);
    check("t2_addr0", 32'(addr_log[0]), 32'd62);
    check("t2_addr1", 32'(addr_log[1]), 32'd63);
    check("t2_addr2", 32'(addr_log[2]), 32'd0);
    check("t2_addr3", 32'(addr_log[3]), 32'd1);
    accept(0, "t2");

    // Back to back with zeros: accumulator must have been cleared.
    fill(8'h00);
    run_op(0, 6'd0, 6'd0, v_edge, rd_cnt, en_cnt, first_rd, first_en);
    check("t3_data", 32'(out_data[0]), 32'h00);
    check("t3_latency", 32'(v_edge), 32'd7);
    accept(0, "t3");

    // Asynchronous reset in READ with k=2.
    fill(8'h80);
    win_base[0] = 6'd3; filt_base[0] = 6'd9; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick(); tick(); tick();
    check("mid_in_read", 32'(rd_en[0]), 32'd1);
    check("mid_k2_addr", 32'(win_addr[0]), 32'd5);
    #2 rst = 1'b0;
    #1;
    check("arst_rd_en", 32'(rd_en[0]), 32'd0);
    check("arst_reg_en", 32'(mac_reg_en[0]), 32'd0);
    check("arst_busy", 32'(busy[0]), 32'd0);
    check("arst_waddr", 32'(win_addr[0]), 32'd0);
    check("arst_valid", 32'(out_valid[0]), 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_valid", 32'(out_valid[0]), 32'd0);
    end
    run_op(0, 6'd30, 6'd40, v_edge, rd_cnt, en_cnt, first_rd, first_en);
    check("t4_latency", 32'(v_edge), 32'd7);
    check("t4_data", 32'(out_data[0]), 32'h10);
    accept(0, "t4");

    // FILT_SIZE=16, all 0xFF: acc 0xFE0 -> 0xFE.
    fill(8'hFF);
    run_op(1, 6'd50, 6'd0, v_edge, rd_cnt, en_cnt, first_rd, first_en);
    check("t5_latency", 32'(v_edge), 32'd19);
    check("t5_rd_cnt", 32'(rd_cnt), 32'd16);
    check("t5_en_cnt", 32'(en_cnt), 32'd16);
    check("t5_data", 32'(out_data[1]), 32'hFE);
    accept(1, "t5");

    // FILT_SIZE=1, 0x80*0x80: acc 0x040 -> 0x04.
    fill(8'h80);
    run_op(2, 6'd7, 6'd8, v_edge, rd_cnt, en_cnt, first_rd, first_en);
    check("t6_latency", 32'(v_edge), 32'd4);
    check("t6_en_cnt", 32'(en_cnt), 32'd1);
    check("t6_data", 32'(out_data[2]), 32'h04);
    accept(2, "t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
